// File: rtl/adjacency_streamer_pkg.sv
// Shared types for the adjacency streamer and its downstream path-accumulation controller.
package adjacency_streamer_pkg;

  localparam int NODE_IDX_WIDTH_DEF  = 9;
  localparam int COUNTER_WIDTH_DEF   = 4;
  localparam int EDGE_ADDR_WIDTH_DEF = 11;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_LOAD,
    S_IDLE,
    S_RD_META,
    S_RD_EDGE,
    S_OUT
  } state_e;

endpackage

// File: rtl/adjacency_streamer_sync_ram.sv
// Simple 1R1W RAM with registered read data (one-cycle read latency).
module adjacency_streamer_sync_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/adjacency_streamer.sv
// Adjacency-list store: loaded edge by edge, then streams each queried node's
// successors one beat at a time with a remaining-edge counter.
module adjacency_streamer
  import adjacency_streamer_pkg::*;
#(
  parameter int NODE_IDX_WIDTH  = NODE_IDX_WIDTH_DEF,
  parameter int COUNTER_WIDTH   = COUNTER_WIDTH_DEF,
  parameter int EDGE_ADDR_WIDTH = EDGE_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_start,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [NODE_IDX_WIDTH-1:0] load_src_idx,
  input  logic [NODE_IDX_WIDTH-1:0] load_dst_idx,
  input  logic                      load_done,
  output logic                      load_err,
  input  logic                      query_valid,
  output logic                      query_ready,
  input  logic [NODE_IDX_WIDTH-1:0] node_idx,
  output logic                      edge_valid,
  input  logic                      edge_ready,
  output logic [NODE_IDX_WIDTH-1:0] next_node_idx,
  output logic [COUNTER_WIDTH-1:0]  next_node_counter,
  output logic                      edge_none,
  output logic                      edge_last
);

  localparam int NW = NODE_IDX_WIDTH;
  localparam int CW = COUNTER_WIDTH;
  localparam int AW = EDGE_ADDR_WIDTH;
  localparam logic [NW-1:0] NODE_MAX = {NW{1'b1}};
  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e state_q, state_d;

  logic [NW-1:0] clr_ptr_q, clr_ptr_d;
  logic [NW-1:0] cur_src_q, cur_src_d;
  logic [CW-1:0] cur_cnt_q, cur_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          wr_full_q, wr_full_d;
  logic          first_edge_q, first_edge_d;
  logic          load_err_q, load_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [NW-1:0] nidx_q, nidx_d;
  logic [CW-1:0] ncnt_q, ncnt_d;
  logic          none_q, none_d;
  logic          last_q, last_d;

  logic          cnt_we, base_we, edge_we;
  logic [NW-1:0] cnt_waddr;
  logic [CW-1:0] cnt_wdata;
  logic [AW-1:0] edge_raddr;
  logic [CW-1:0] count_rdata;
  logic [AW-1:0] base_rdata;
  logic [NW-1:0] edge_rdata;
  logic          new_src, edge_adv;

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    cur_src_d    = cur_src_q;
    cur_cnt_d    = cur_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    wr_full_d    = wr_full_q;
    first_edge_d = first_edge_q;
    load_err_d   = load_err_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    nidx_d       = nidx_q;
    ncnt_d       = ncnt_q;
    none_d       = none_q;
    last_d       = last_q;
    cnt_we       = 1'b0;
    base_we      = 1'b0;
    edge_we      = 1'b0;
    cnt_waddr    = load_src_idx;
    cnt_wdata    = '0;
    edge_raddr   = ptr_q;
    new_src      = 1'b0;
    edge_adv     = 1'b0;

    case (state_q)
      S_CLEAR: begin
        cnt_we       = 1'b1;
        cnt_waddr    = clr_ptr_q;
        clr_ptr_d    = clr_ptr_q + NW'(1);
        wr_ptr_d     = '0;
        wr_full_d    = 1'b0;
        cur_src_d    = '0;
        cur_cnt_d    = '0;
        first_edge_d = 1'b1;
        load_err_d   = 1'b0;
        if (clr_ptr_q == NODE_MAX) begin
          clr_ptr_d = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          new_src = first_edge_q || (load_src_idx != cur_src_q);
          if (!first_edge_q && (load_src_idx < cur_src_q)) begin
            load_err_d = 1'b1;
          end else if (wr_full_q) begin
            load_err_d = 1'b1;
          end else if (new_src) begin
            cnt_we       = 1'b1;
            cnt_wdata    = CNT_ONE;
            base_we      = 1'b1;
            cur_src_d    = load_src_idx;
            cur_cnt_d    = CNT_ONE;
            first_edge_d = 1'b0;
            edge_adv     = 1'b1;
          end else if (cur_cnt_q == CNT_MAX) begin
            load_err_d = 1'b1;
          end else begin
            cnt_we    = 1'b1;
            cnt_wdata = cur_cnt_q + CNT_ONE;
            cur_cnt_d = cur_cnt_q + CNT_ONE;
            edge_adv  = 1'b1;
          end
          // Last slot is still usable; afterwards the pointer parks and flags.
          if (edge_adv) begin
            edge_we = 1'b1;
            if (wr_ptr_q == ADDR_MAX) wr_full_d = 1'b1;
            else                      wr_ptr_d  = wr_ptr_q + AW'(1);
          end
        end
        if (load_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (query_valid) state_d = S_RD_META;
      end
      S_RD_META: begin
        cnt_d = count_rdata;
        ptr_d = base_rdata;
        if (count_rdata == '0) begin
          nidx_d  = '0;
          ncnt_d  = '0;
          none_d  = 1'b1;
          last_d  = 1'b1;
          state_d = S_OUT;
        end else begin
          edge_raddr = base_rdata;
          none_d     = 1'b0;
          state_d    = S_RD_EDGE;
        end
      end
      S_RD_EDGE: begin
        nidx_d  = edge_rdata;
        ncnt_d  = cnt_q - CNT_ONE;
        last_d  = (cnt_q == CNT_ONE);
        none_d  = 1'b0;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (edge_ready) begin
          if (last_q) begin
            state_d = S_IDLE;
          end else begin
            ptr_d      = ptr_q + AW'(1);
            cnt_d      = cnt_q - CNT_ONE;
            edge_raddr = ptr_q + AW'(1);
            state_d    = S_RD_EDGE;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase

    if (load_start) begin
      state_d   = S_CLEAR;
      clr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_CLEAR;
      clr_ptr_q    <= '0;
      cur_src_q    <= '0;
      cur_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      wr_full_q    <= 1'b0;
      first_edge_q <= 1'b1;
      load_err_q   <= 1'b0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      nidx_q       <= '0;
      ncnt_q       <= '0;
      none_q       <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      cur_src_q    <= cur_src_d;
      cur_cnt_q    <= cur_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_full_q    <= wr_full_d;
      first_edge_q <= first_edge_d;
      load_err_q   <= load_err_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      nidx_q       <= nidx_d;
      ncnt_q       <= ncnt_d;
      none_q       <= none_d;
      last_q       <= last_d;
    end
  end

  // Meta tables are read every cycle at node_idx; only the S_IDLE handshake read is consumed.
  adjacency_streamer_sync_ram #(.WIDTH(CW), .ADDR_W(NW)) u_count_mem (
    .clk(clk), .we(cnt_we), .waddr(cnt_waddr), .wdata(cnt_wdata),
    .raddr(node_idx), .rdata(count_rdata)
  );

  adjacency_streamer_sync_ram #(.WIDTH(AW), .ADDR_W(NW)) u_base_mem (
    .clk(clk), .we(base_we), .waddr(load_src_idx), .wdata(wr_ptr_q),
    .raddr(node_idx), .rdata(base_rdata)
  );

  adjacency_streamer_sync_ram #(.WIDTH(NW), .ADDR_W(AW)) u_edge_mem (
    .clk(clk), .we(edge_we), .waddr(wr_ptr_q), .wdata(load_dst_idx),
    .raddr(edge_raddr), .rdata(edge_rdata)
  );

  assign load_ready        = (state_q == S_LOAD);
  assign query_ready       = (state_q == S_IDLE);
  assign edge_valid        = (state_q == S_OUT);
  assign load_err          = load_err_q;
  assign next_node_idx     = nidx_q;
  assign next_node_counter = ncnt_q;
  assign edge_none         = none_q;
  assign edge_last         = last_q;

endmodule

// File: tb/tb_adjacency_streamer.sv
// Directed bench for adjacency_streamer: load, query, saturation, ordering, backpressure, abort.
module tb_adjacency_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_start = 1'b0, load_valid = 1'b0, load_done = 1'b0;
  logic       load_ready, load_err;
  logic [8:0] load_src_idx = '0, load_dst_idx = '0;
  logic       query_valid = 1'b0, query_ready;
  logic [8:0] node_idx = '0;
  logic       edge_valid, edge_ready = 1'b1;
  logic [8:0] next_node_idx;
  logic [3:0] next_node_counter;
  logic       edge_none, edge_last;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adjacency_streamer dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_ready(load_ready),
    .load_src_idx(load_src_idx), .load_dst_idx(load_dst_idx),
    .load_done(load_done), .load_err(load_err),
    .query_valid(query_valid), .query_ready(query_ready), .node_idx(node_idx),
    .edge_valid(edge_valid), .edge_ready(edge_ready),
    .next_node_idx(next_node_idx), .next_node_counter(next_node_counter),
    .edge_none(edge_none), .edge_last(edge_last)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Clear sweep is 512 edges counted from the edge that entered S_CLEAR.
  task automatic wait_clear(input string tag);
    repeat (511) step;
    chk({tag, "_ready_early"}, load_ready, 0);
    step;
    chk({tag, "_ready"}, load_ready, 1);
  endtask

  task automatic do_load_start(input string tag);
    load_start = 1'b1;
    step;
    load_start = 1'b0;
    chk({tag, "_edge_valid"}, edge_valid, 0);
    wait_clear(tag);
  endtask

  task automatic load_edge(input int src, input int dst, input logic done);
    load_valid   = 1'b1;
    load_src_idx = 9'(src);
    load_dst_idx = 9'(dst);
    load_done    = done;
    step;
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  task automatic query(input int n);
    query_valid = 1'b1;
    node_idx    = 9'(n);
    step;
    query_valid = 1'b0;
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    while (!edge_valid && l < 40) begin
      step;
      l++;
    end
  endtask

  // lat = edges from the previous handshake until edge_valid is seen.
  task automatic beat(input string tag, input int idx, input int cnt,
                      input int none, input int last, input int lat);
    int l;
    wait_valid(l);
    chk({tag, "_lat"}, l, lat);
    chk({tag, "_idx"}, next_node_idx, idx);
    chk({tag, "_cnt"}, next_node_counter, cnt);
    chk({tag, "_none"}, edge_none, none);
    chk({tag, "_last"}, edge_last, last);
    step;
  endtask

  initial begin
    int l;
    int bad;
    #12;
    chk("rst_load_ready", load_ready, 0);
    chk("rst_query_ready", query_ready, 0);
    chk("rst_edge_valid", edge_valid, 0);
    chk("rst_edge_none", edge_none, 0);
    chk("rst_edge_last", edge_last, 0);
    chk("rst_next_idx", next_node_idx, 0);
    chk("rst_next_cnt", next_node_counter, 0);
    chk("rst_load_err", load_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("rst");

    // basic load with load_done on the last beat
    load_edge(5, 7, 1'b0);
    load_edge(5, 9, 1'b0);
    load_edge(6, 3, 1'b1);
    chk("idle_query_ready", query_ready, 1);
    chk("idle_load_ready", load_ready, 0);
    chk("idle_load_err", load_err, 0);
    query(5);
    beat("q5a", 7, 1, 0, 0, 2);
    beat("q5b", 9, 0, 0, 1, 1);
    chk("q5_back_idle", query_ready, 1);
    query(100);
    beat("q100", 0, 0, 1, 1, 1);
    query(6);
    beat("q6", 3, 0, 0, 1, 2);

    // 17 edges from one source: count saturates at 15
    do_load_start("ls1");
    for (int i = 0; i < 17; i++) load_edge(2, 10 + i, i == 16);
    chk("sat_err", load_err, 1);
    query(2);
    for (int i = 0; i < 15; i++) beat("q2", 10 + i, 14 - i, 0, (i == 14) ? 1 : 0, (i == 0) ? 2 : 1);
    chk("q2_back_idle", query_ready, 1);

    // descending source is rejected
    do_load_start("ls2");
    chk("ls2_err_cleared", load_err, 0);
    load_edge(6, 1, 1'b0);
    load_edge(5, 2, 1'b1);
    chk("ord_err", load_err, 1);
    query(5);
    beat("ord_q5", 0, 0, 1, 1, 1);
    query(6);
    beat("ord_q6", 1, 0, 0, 1, 2);

    // backpressure on first beat
    do_load_start("ls3");
    load_edge(5, 7, 1'b0);
    load_edge(5, 9, 1'b0);
    load_edge(5, 11, 1'b1);
    chk("bp_err", load_err, 0);
    edge_ready = 1'b0;
    query(5);
    wait_valid(l);
    chk("bp_lat", l, 2);
    bad = 0;
    repeat (10) begin
      step;
      if (edge_valid !== 1'b1 || next_node_idx !== 9'd7 ||
          next_node_counter !== 4'd2 || edge_last !== 1'b0) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_idx", next_node_idx, 7);
    edge_ready = 1'b1;
    step;
    beat("bp2", 9, 1, 0, 0, 1);
    beat("bp3", 11, 0, 0, 1, 1);

    // abort mid-stream
    query(5);
    beat("ms1", 7, 2, 0, 0, 2);
    wait_valid(l);
    chk("ms2_lat", l, 1);
    edge_ready = 1'b0;
    do_load_start("ls4");
    edge_ready = 1'b1;
    load_done  = 1'b1;
    step;
    load_done  = 1'b0;
    chk("ms_idle", query_ready, 1);
    query(5);
    beat("ms_none", 0, 0, 1, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
